// File: rtl/mult_sched_pkg.sv
// Shared definitions for the multiplier-sharing scheduler.
// State encoding and default iteration limit.
package mult_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    CALC = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int MAX_ITER_DEF = 255;

endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or
// after the pointer, wrapping around.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] win_o,
  output logic [IDW-1:0]  idx_o
);

  logic found;
  int   k;

  always_comb begin
    win_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr_i) + i) % NREQ;
      if (!found && req_i[k]) begin
        found    = 1'b1;
        win_o[k] = 1'b1;
        idx_o    = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one repeated-addition
// multiplier datapath among NREQ requesters.
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int MAX_ITER = MAX_ITER_DEF,
  parameter int CNTW     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  sel,
  output logic            ldA,
  output logic            ldB,
  output logic            clrP,
  output logic            ldP,
  output logic            decB,
  input  logic            eqz,
  output logic            busy,
  output logic            done_vld,
  output logic [IDW-1:0]  done_id,
  output logic            err
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  idx_q, idx_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0] iter_q, iter_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] win_oh;
  logic [IDW-1:0]  win_idx;
  logic [IDW-1:0]  idx_nxt;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (win_oh),
    .idx_o (win_idx)
  );

  assign idx_nxt = (idx_q == IDW'(NREQ-1)) ?
                   '0 : idx_q + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  // ldP/decB are gated by eqz in the same cycle so B=0
  // finishes with no accumulate cycle at all.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    iter_d  = iter_q;
    err_d   = err_q;
    ldP     = 1'b0;
    decB    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|win_oh) begin
          idx_d   = win_idx;
          state_d = LDA;
        end
      end
      LDA: state_d = LDB;
      LDB: begin
        iter_d  = '0;
        err_d   = 1'b0;
        state_d = CALC;
      end
      CALC: begin
        if (eqz) begin
          err_d   = 1'b0;
          state_d = DONE;
        end else if (iter_q == CNTW'(MAX_ITER)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          ldP    = 1'b1;
          decB   = 1'b1;
          iter_d = iter_q + CNTW'(1);
        end
      end
      DONE: begin
        ptr_d   = idx_nxt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign ldA      = (state_q == LDA);
  assign ldB      = (state_q == LDB);
  assign clrP     = (state_q == LDB);
  assign done_vld = (state_q == DONE);
  assign done_id  = done_vld ? idx_q : '0;
  assign err      = done_vld & err_q;
  assign sel      = busy ? idx_q : '0;
  assign gnt      = busy ?
                    ({{(NREQ-1){1'b0}}, 1'b1} << idx_q) :
                    '0;

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched with a behavioural
// repeated-addition datapath attached.
module tb_mult_share_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       ldA, ldB, clrP, ldP, decB, eqz;
  logic       busy, done_vld, err;
  logic [1:0] done_id;

  logic [7:0]  opA [4];
  logic [7:0]  opB [4];
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [15:0] P = '0;
  logic        force0 = 1'b0;
  logic [15:0] outs;

  int n_assert = 0;
  int n_fail   = 0;
  int viol     = 0;
  int cyc, ldp_cnt, decb_cnt, gnt_cnt, got;
  int d_id, d_err, d_p;

  always #5 clk = ~clk;

  mult_share_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .sel      (sel),
    .ldA      (ldA),
    .ldB      (ldB),
    .clrP     (clrP),
    .ldP      (ldP),
    .decB     (decB),
    .eqz      (eqz),
    .busy     (busy),
    .done_vld (done_vld),
    .done_id  (done_id),
    .err      (err)
  );

  // datapath model
  always @(posedge clk) begin
    if (ldA) A <= opA[sel];
    if (ldB) B <= opB[sel];
    else if (decB) B <= B - 8'd1;
    if (clrP) P <= '0;
    else if (ldP) P <= P + {8'd0, A};
  end

  assign eqz  = force0 ? 1'b0 : (B == 8'd0);
  assign outs = {gnt, sel, ldA, ldB, clrP, ldP, decB,
                 busy, done_vld, done_id, err};

  always @(negedge clk) begin
    if (rst_n &&
        ((int'(ldA) + int'(ldB) + int'(ldP)) > 1 ||
         !$onehot0(gnt)))
      viol++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic run_job(input string tag, input int budget);
    cyc = 0; ldp_cnt = 0; decb_cnt = 0;
    gnt_cnt = 0; got = 0;
    while (got == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (ldP) ldp_cnt++;
      if (decB) decb_cnt++;
      if (gnt != 4'd0) gnt_cnt++;
      if (done_vld) begin
        got   = 1;
        d_id  = int'(done_id);
        d_err = int'(err);
        d_p   = int'(P);
      end
    end
    check({tag, "_done_seen"}, got, 1);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end
    rst_n = 1'b0;
    req   = 4'd0;
    #1;
    check("reset_outs", outs, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", outs, 0);

    // 1: single job 7*3
    opA[0] = 8'd7; opB[0] = 8'd3;
    req = 4'b0001;
    run_job("t1", 50);
    check("t1_id", d_id, 0);
    check("t1_err", d_err, 0);
    check("t1_p", d_p, 21);
    check("t1_ldp", ldp_cnt, 3);
    check("t1_gnt_cycles", gnt_cnt, 7);
    req = 4'd0;
    @(negedge clk);
    check("t1_pulse_once", {done_vld, busy}, 0);

    // 2: B=0 finishes with no accumulate
    opA[2] = 8'd9; opB[2] = 8'd0;
    req = 4'b0100;
    run_job("t2", 50);
    check("t2_id", d_id, 2);
    check("t2_err", d_err, 0);
    check("t2_p", d_p, 0);
    check("t2_ldp", ldp_cnt, 0);
    check("t2_decb", decb_cnt, 0);
    check("t2_gnt_cycles", gnt_cnt, 4);
    req = 4'd0;

    // 3: all requesting, fresh pointer
    rst_pulse();
    for (int i = 0; i < 4; i++) begin
      opA[i] = 8'(i + 2);
      opB[i] = 8'd1;
    end
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      run_job("t3", 50);
      check("t3_id", d_id, j % 4);
      check("t3_p", d_p, (j % 4) + 2);
      check("t3_cycles", cyc, (j == 0) ? 5 : 6);
    end
    req = 4'd0;

    // 4: eqz stuck low -> abort at MAX_ITER
    force0 = 1'b1;
    req = 4'b0001;
    run_job("t4", 600);
    check("t4_ldp", ldp_cnt, 255);
    check("t4_err", d_err, 1);
    check("t4_id", d_id, 0);
    check("t4_gnt_cycles", gnt_cnt, 259);
    req = 4'd0;
    force0 = 1'b0;
    @(negedge clk);

    // 5: reset during CALC
    opA[2] = 8'd5; opB[2] = 8'd20;
    req = 4'b0100;
    repeat (4) @(negedge clk);
    check("t5_in_calc", {ldP, gnt}, 5'b1_0100);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_outs", outs, 0);
    opB[2] = 8'd4;
    got = 0;
    repeat (2) begin
      @(negedge clk);
      if (done_vld) got++;
    end
    check("t5_no_done", got, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_restart_lda", {ldA, gnt}, 5'b1_0100);
    run_job("t5", 50);
    check("t5_id", d_id, 2);
    check("t5_err", d_err, 0);
    check("t5_p", d_p, 20);
    req = 4'd0;

    // 6: requester drops req after grant
    rst_pulse();
    opA[1] = 8'd3; opB[1] = 8'd2;
    opA[3] = 8'd6; opB[3] = 8'd2;
    req = 4'b1010;
    @(negedge clk);
    check("t6_gnt1", gnt, 4'b0010);
    req = 4'b1000;
    run_job("t6a", 50);
    check("t6a_id", d_id, 1);
    check("t6a_p", d_p, 6);
    run_job("t6b", 50);
    check("t6b_id", d_id, 3);
    check("t6b_p", d_p, 12);
    check("t6b_cycles", cyc, 7);
    req = 4'd0;
    @(negedge clk);
    check("t6_idle", {done_vld, busy}, 0);

    check("strobe_exclusive", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
